// File: rtl/simple_bus_reg_target.sv
// simple_bus_reg_target: SimpleBus responder backed by a byte-wide register bank.
// Claims page BASE_UPPER; a read answers RD_WAIT cycles after its read-sample
// edge, a write commits when the initiator raises dataValid or aborts after
// WR_TIMEOUT cycles. Split (tristate-free) outputs with separate enables.
// Optional build macro SIMPLE_BUS_TGT_STATS_EN adds saturating transaction counters.
module simple_bus_reg_target #(
  parameter logic [7:0] BASE_UPPER = 8'h04,
  parameter int         DEPTH      = 32,
  parameter int         RD_WAIT    = 3,
  parameter int         WR_TIMEOUT = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     read,
  input  logic [7:0]               address,
  input  logic [7:0]               data_in,
  input  logic                     dv_in,
  output logic [7:0]               data_out,
  output logic                     data_oe,
  output logic                     dv_out,
  output logic                     dv_oe,
  input  logic                     lcl_we,
  input  logic [$clog2(DEPTH)-1:0] lcl_addr,
  input  logic [7:0]               lcl_wdata,
`ifdef SIMPLE_BUS_TGT_STATS_EN
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count,
  output logic [7:0]               to_count,
`endif
  output logic                     wr_timeout_pulse
);

  localparam int         IW       = $clog2(DEPTH);
  localparam logic [8:0] DEPTH_W  = 9'(DEPTH);
  localparam int         SKIP_CYC = 10;

  if (RD_WAIT < 2 || RD_WAIT > 10) begin : g_bad_rd_wait
    $error("simple_bus_reg_target: RD_WAIT must be 2..10");
  end
  if (WR_TIMEOUT < 2 || WR_TIMEOUT > 255) begin : g_bad_wr_timeout
    $error("simple_bus_reg_target: WR_TIMEOUT must be 2..255");
  end
  if (DEPTH < 2 || DEPTH > 256 || (1 << IW) != DEPTH) begin : g_bad_depth
    $error("simple_bus_reg_target: DEPTH must be a power of 2 in 2..256");
  end

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RD_WAIT, S_WR_WAIT, S_SKIP} state_t;

  state_t        r_state, w_nstate;
  logic [7:0]    r_cnt, w_ncnt;
  logic          r_sel;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_mem [DEPTH];
  logic          r_to_pulse;
  logic          w_bus_we, w_to, w_drive, w_lo_ok;

  // Bus drive comes purely from registered state, so the enables cannot glitch.
  assign w_drive = (r_state == S_RD_WAIT) && (r_cnt == 8'd0);
  assign w_lo_ok = {1'b0, address} < DEPTH_W;

  assign data_oe          = w_drive;
  assign dv_oe            = w_drive;
  assign dv_out           = w_drive;
  assign data_out         = w_drive ? r_mem[r_idx] : 8'h00;
  assign wr_timeout_pulse = r_to_pulse;

  // Next-state, counter reload and write/abort decode.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_bus_we = 1'b0;
    w_to     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_nstate = S_ADDR;
      S_ADDR: begin
        if (r_sel && w_lo_ok) begin
          if (read) begin
            w_nstate = S_RD_WAIT;
            w_ncnt   = 8'(RD_WAIT - 1);
          end else begin
            w_nstate = S_WR_WAIT;
            w_ncnt   = 8'(WR_TIMEOUT);
          end
        end else begin
          w_nstate = S_SKIP;
          w_ncnt   = 8'(SKIP_CYC - 1);
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == 8'd0) w_nstate = S_IDLE;
        else               w_ncnt   = r_cnt - 8'd1;
      end
      S_WR_WAIT: begin
        if (dv_in) begin
          w_bus_we = 1'b1;
          w_nstate = S_IDLE;
        end else if (r_cnt == 8'd0) begin
          w_to     = 1'b1;
          w_nstate = S_IDLE;
        end else begin
          w_ncnt   = r_cnt - 8'd1;
        end
      end
      S_SKIP: begin
        // Leave when someone else completes, or give up so a dead bus cannot hang us.
        if (dv_in || r_cnt == 8'd0) w_nstate = S_IDLE;
        else                        w_ncnt   = r_cnt - 8'd1;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // State, counter, address latches and timeout pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_sel      <= 1'b0;
      r_idx      <= '0;
      r_to_pulse <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_cnt      <= w_ncnt;
      r_to_pulse <= w_to;
      if (r_state == S_IDLE && start) r_sel <= (address == BASE_UPPER);
      if (r_state == S_ADDR)          r_idx <= address[IW-1:0];
    end
  end

  // Register bank; the bus write is applied last so it wins an index collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      if (lcl_we)   r_mem[lcl_addr] <= lcl_wdata;
      if (w_bus_we) r_mem[r_idx]    <= data_in;
    end
  end

`ifdef SIMPLE_BUS_TGT_STATS_EN
  // Saturating completion counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
      to_count <= 8'd0;
    end else begin
      if (w_drive  && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (w_bus_we && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (w_to     && to_count != 8'hFF)    to_count <= to_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simple_bus_reg_target.sv
// Bench for simple_bus_reg_target: directed bus transactions, expected read
// data queued at issue time and checked by a separate monitor on negedge.
module tb_simple_bus_reg_target;
  localparam int RD_WAIT    = 3;
  localparam int WR_TIMEOUT = 7;

  logic       clock = 1'b0, reset = 1'b1;
  logic       start = 1'b0, read = 1'b0, dv_in = 1'b0;
  logic [7:0] address = 8'h00, data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe, dv_out, dv_oe, wr_timeout_pulse;
  logic       lcl_we = 1'b0;
  logic [4:0] lcl_addr = 5'd0;
  logic [7:0] lcl_wdata = 8'h00;
`ifdef SIMPLE_BUS_TGT_STATS_EN
  logic [15:0] rd_count, wr_count;
  logic [7:0]  to_count;
`endif

  simple_bus_reg_target #(.BASE_UPPER(8'h04), .DEPTH(32), .RD_WAIT(RD_WAIT),
                          .WR_TIMEOUT(WR_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .read(read), .address(address),
    .data_in(data_in), .dv_in(dv_in), .data_out(data_out), .data_oe(data_oe),
    .dv_out(dv_out), .dv_oe(dv_oe), .lcl_we(lcl_we), .lcl_addr(lcl_addr),
    .lcl_wdata(lcl_wdata),
`ifdef SIMPLE_BUS_TGT_STATS_EN
    .rd_count(rd_count), .wr_count(wr_count), .to_count(to_count),
`endif
    .wr_timeout_pulse(wr_timeout_pulse));

  always #5 clock = ~clock;

  int         n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the target drives the bus must match the oldest queued read.
  always @(negedge clock) begin
    if (dv_oe === 1'b1 || data_oe === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_drive: data_oe=%b dv_oe=%b data_out=%h with no read pending",
                 data_oe, dv_oe, data_out);
      end else begin
        chk("rd_resp", {data_oe, dv_oe, dv_out, data_out}, {3'b111, exp_q.pop_front()});
      end
    end
  end

  // Two address phases; called and returns 1 time unit after a posedge.
  task automatic addr_phase(input logic [15:0] a, input logic rd);
    start = 1'b1; address = a[15:8];
    @(posedge clock); #1;
    start = 1'b0; address = a[7:0]; read = rd;
    @(posedge clock); #1;
    read = 1'b0; address = 8'h00;
  endtask

  // Read with latency check; optional local write during the drive cycle.
  task automatic do_read(input logic [15:0] a, input logic [7:0] e,
                         input logic lw, input logic [7:0] lwd);
    int lat;
    exp_q.push_back(e);
    addr_phase(a, 1'b1);
    lat = 0;
    // k counts cycles after the read-sample edge; k=1 is the cycle it starts.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (dv_oe === 1'b1) begin
        lat = k;
        if (lw) begin lcl_we = 1'b1; lcl_addr = a[4:0]; lcl_wdata = lwd; end
        break;
      end
    end
    chk("rd_latency", lat, RD_WAIT);
    if (lat == 0 && exp_q.size() != 0) void'(exp_q.pop_back());
    @(posedge clock); #1;
    lcl_we = 1'b0;
  endtask

  // Write: dataValid dly cycles after the address phase, optional same-cycle local write.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int dly,
                          input logic lw, input logic [4:0] la, input logic [7:0] ld);
    addr_phase(a, 1'b0);
    for (int i = 1; i < dly; i++) begin @(posedge clock); #1; end
    dv_in = 1'b1; data_in = d;
    lcl_we = lw; lcl_addr = la; lcl_wdata = ld;
    @(posedge clock); #1;
    dv_in = 1'b0; data_in = 8'h00; lcl_we = 1'b0;
    @(negedge clock);
    chk("wr_no_timeout", wr_timeout_pulse, 1'b0);
    @(posedge clock); #1;
  endtask

  // Write with no dataValid: pulse opens WR_TIMEOUT+1 edges after the write-sample
  // edge, i.e. in cycle index WR_TIMEOUT+2 counting that edge's cycle as 1.
  task automatic do_timeout(input logic [15:0] a);
    int first, width;
    addr_phase(a, 1'b0);
    first = 0; width = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (wr_timeout_pulse === 1'b1) begin
        width++;
        if (first == 0) first = k;
      end
    end
    chk("to_pulse_pos", first, WR_TIMEOUT + 2);
    chk("to_pulse_width", width, 1);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_outs", {data_out, data_oe, dv_out, dv_oe, wr_timeout_pulse}, 12'h000);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("idle_outs", {data_out, data_oe, dv_out, dv_oe, wr_timeout_pulse}, 12'h000);
    @(posedge clock); #1;

    // Basic read, write then read back
    do_read(16'h0400, 8'h00, 1'b0, 8'h00);
    do_write(16'h0406, 8'hDC, 2, 1'b0, 5'd0, 8'h00);
    do_read(16'h0406, 8'hDC, 1'b0, 8'h00);

    // Write timeout leaves the register untouched; next start accepted
    do_timeout(16'h0406);
    do_read(16'h0406, 8'hDC, 1'b0, 8'h00);

    // Page miss released by external dataValid, then immediate new read
    addr_phase(16'h0506, 1'b1);
    dv_in = 1'b1;
    @(posedge clock); #1;
    dv_in = 1'b0;
    do_read(16'h0406, 8'hDC, 1'b0, 8'h00);

    // Index miss released by the 10-cycle bound; local write on drive cycle
    addr_phase(16'h0420, 1'b1);
    repeat (10) begin @(posedge clock); #1; end
    do_read(16'h0406, 8'hDC, 1'b1, 8'h77);
    do_read(16'h0406, 8'h77, 1'b0, 8'h00);

    // Bus vs local write collisions
    do_write(16'h0403, 8'hAA, 1, 1'b1, 5'd3, 8'h55);
    do_read(16'h0403, 8'hAA, 1'b0, 8'h00);
    do_write(16'h0403, 8'hAA, 2, 1'b1, 5'd4, 8'h55);
    do_read(16'h0404, 8'h55, 1'b0, 8'h00);
    do_read(16'h0403, 8'hAA, 1'b0, 8'h00);

    // Reset during RD_WAIT: no response, register bank cleared
    addr_phase(16'h0406, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (6) begin @(posedge clock); #1; end
    do_read(16'h0406, 8'h00, 1'b0, 8'h00);

    // Traffic for the counters: 1 read above, 2 writes, 1 timeout
    do_write(16'h0406, 8'hDC, 2, 1'b0, 5'd0, 8'h00);
    do_write(16'h0407, 8'h11, 3, 1'b0, 5'd0, 8'h00);
    do_timeout(16'h0406);
`ifdef SIMPLE_BUS_TGT_STATS_EN
    chk("rd_count", rd_count, 1);
    chk("wr_count", wr_count, 2);
    chk("to_count", to_count, 1);
`endif
    do_read(16'h0407, 8'h11, 1'b0, 8'h00);

    repeat (3) @(posedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
